// File: rtl/complex_mac_acc_if.sv
// rtl/complex_mac_acc_if.sv - operand stream and multiplier handshake bundle for complex_mac_acc
interface complex_mac_acc_if;
    logic        op_valid;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic        op_ready;
    logic [7:0]  mult_a;
    logic [7:0]  mult_b;
    logic        mult_start;
    logic        mult_ready;
    logic [15:0] mult_out;

    // Environment side: requester plus multiplier
    modport master (
        output op_valid, op_a, op_b, mult_ready, mult_out,
        input  op_ready, mult_a, mult_b, mult_start
    );

    // Accumulator side
    modport slave (
        input  op_valid, op_a, op_b, mult_ready, mult_out,
        output op_ready, mult_a, mult_b, mult_start
    );
endinterface

// File: rtl/complex_mac_acc.sv
// rtl/complex_mac_acc.sv - complex product accumulator driving a start/ready multiplier
module complex_mac_acc #(
    parameter int ACC_W   = 12,
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             acc_start,
    input  logic [LEN_W-1:0] len,
    complex_mac_acc_if.slave bus,
    output logic [ACC_W-1:0] acc_re,
    output logic [ACC_W-1:0] acc_im,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic             timeout_err
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET,
        S_ISSUE,
        S_WAIT_LOW,
        S_WAIT_HIGH,
        S_DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [LEN_W-1:0] cnt_q;
    logic [WD_W-1:0]  wd_q;
    logic [7:0]       mult_a_q;
    logic [7:0]       mult_b_q;
    logic             zero_done_q;

    logic             wd_expired;
    logic             timeout_hit;
    logic             accept_start;
    logic             op_fire;
    logic             capture;
    logic [ACC_W-1:0] prod_re;
    logic [ACC_W-1:0] prod_im;
    logic [ACC_W-1:0] sum_re;
    logic [ACC_W-1:0] sum_im;
    logic             ovf_re;
    logic             ovf_im;

    assign wd_expired   = (wd_q == WD_W'(TIMEOUT - 1));
    assign accept_start = (state_q == S_IDLE) && acc_start;
    assign op_fire      = (state_q == S_GET) && bus.op_valid;
    assign capture      = (state_q == S_WAIT_HIGH) && bus.mult_ready;

    // Product halves are 8-bit two's complement; widen before accumulating
    assign prod_re = {{(ACC_W-8){bus.mult_out[15]}}, bus.mult_out[15:8]};
    assign prod_im = {{(ACC_W-8){bus.mult_out[7]}},  bus.mult_out[7:0]};
    assign sum_re  = acc_re + prod_re;
    assign sum_im  = acc_im + prod_im;
    assign ovf_re  = (acc_re[ACC_W-1] == prod_re[ACC_W-1]) && (sum_re[ACC_W-1] != acc_re[ACC_W-1]);
    assign ovf_im  = (acc_im[ACC_W-1] == prod_im[ACC_W-1]) && (sum_im[ACC_W-1] != acc_im[ACC_W-1]);

    assign bus.mult_a = mult_a_q;
    assign bus.mult_b = mult_b_q;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a stuck multiplier handshake is abandoned through DONE
    always_comb begin
        state_d     = state_q;
        timeout_hit = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (acc_start && (len != '0)) begin
                    state_d = S_GET;
                end
            end
            S_GET: begin
                if (bus.op_valid) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus.mult_ready) begin
                    state_d = S_WAIT_LOW;
                end else if (wd_expired) begin
                    state_d     = S_DONE;
                    timeout_hit = 1'b1;
                end
            end
            S_WAIT_LOW: begin
                if (!bus.mult_ready) begin
                    state_d = S_WAIT_HIGH;
                end else if (wd_expired) begin
                    state_d     = S_DONE;
                    timeout_hit = 1'b1;
                end
            end
            S_WAIT_HIGH: begin
                if (bus.mult_ready) begin
                    state_d = (cnt_q == LEN_W'(1)) ? S_DONE : S_GET;
                end else if (wd_expired) begin
                    state_d     = S_DONE;
                    timeout_hit = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Handshake and status outputs decoded from the current state
    always_comb begin
        bus.op_ready   = 1'b0;
        bus.mult_start = 1'b0;
        busy           = 1'b1;
        done           = zero_done_q;
        case (state_q)
            S_IDLE:  busy           = 1'b0;
            S_GET:   bus.op_ready   = 1'b1;
            S_ISSUE: bus.mult_start = bus.mult_ready;
            S_DONE:  done           = 1'b1;
            default: ;
        endcase
    end

    // Watchdog restarts on every state change and saturates so it never wraps
    always_ff @(posedge clk) begin
        if (!rst) begin
            wd_q <= '0;
        end else if (state_d != state_q) begin
            wd_q <= '0;
        end else if (!wd_expired) begin
            wd_q <= wd_q + WD_W'(1);
        end
    end

    // Operand latch, term counter, accumulators and sticky flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q       <= '0;
            mult_a_q    <= '0;
            mult_b_q    <= '0;
            acc_re      <= '0;
            acc_im      <= '0;
            ovf         <= 1'b0;
            timeout_err <= 1'b0;
            zero_done_q <= 1'b0;
        end else begin
            zero_done_q <= 1'b0;
            if (accept_start) begin
                acc_re      <= '0;
                acc_im      <= '0;
                ovf         <= 1'b0;
                timeout_err <= 1'b0;
                cnt_q       <= len;
                zero_done_q <= (len == '0);
            end
            if (op_fire) begin
                mult_a_q <= bus.op_a;
                mult_b_q <= bus.op_b;
            end
            if (capture) begin
                acc_re <= sum_re;
                acc_im <= sum_im;
                cnt_q  <= cnt_q - LEN_W'(1);
                if (ovf_re || ovf_im) begin
                    ovf <= 1'b1;
                end
            end
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end
        end
    end
endmodule
